spi_slave_regmem: RTL

//  Parametrised SPI slave register memory and the successor to the fixed SPI slave memory.
//  cs_n, sclk and mosi are oversampled and synchronised into the system clock domain.

---
 rtl/spi_slave_regmem.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regmem.sv
// spi_slave_regmem
//   SPI slave register memory with configurable address/data width and depth.
//   The SPI pins are oversampled in the system clock domain. A frame is
//   RW | ADDR | DATA x N, MSB first. Bursts auto-increment the address and wrap
//   at DEPTH-1. Frame status is reported as single-cycle pulses.
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   cs_n, sclk, mosi      SPI pins from the master (asynchronous to clk)
//   miso, miso_oe         serial read data and its pad output enable
//   busy                  synchronised chip select is active
//   frame_done, err_short pulses: clean frame end / aborted frame
module spi_slave_regmem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter bit CPOL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic frame_done,
  output logic err_short
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  state_t state, state_n;

  logic [2:0]        cs_q;
  logic [2:0]        sclk_q;
  logic [1:0]        mosi_q;
  logic [CNT_W-1:0]  cnt;
  logic              rw;
  logic              words_done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              miso_q;
  logic              done_c;
  logic              err_c;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
  logic [ADDR_W-1:0] addr_nx, addr_inc;
  logic [DATA_W-1:0] rx_nx;
  logic              addr_ok;

  // Bit 1 is the synchronised level, bit 2 the previous level for edge detection.
  // cs_n resets high so busy is low out of reset; sclk resets to its idle level
  // so no spurious edge is seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 3'b111;
      sclk_q <= {3{CPOL}};
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], cs_n};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign cs_fall   =  cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] &  cs_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign mosi_s    = mosi_q[1];
  assign busy      = ~cs_q[1];

  assign addr_nx  = ADDR_W'({addr, mosi_s});
  assign rx_nx    = DATA_W'({rx_sh, mosi_s});
  assign addr_inc = (addr == ADDR_TOP) ? '0 : addr + ADDR_W'(1);
  assign addr_ok  = ({1'b0, addr} < DEPTH_X);

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    rd_word = ({1'b0, a} < DEPTH_X) ? mem[a] : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A chip-select release takes priority over any sclk edge in the same cycle,
  // so a word whose last bit coincides with it is never committed.
  always_comb begin
    state_n = state;
    done_c  = 1'b0;
    err_c   = 1'b0;
    if (cs_rise) begin
      state_n = IDLE;
      if (state == DATA && cnt == '0 && words_done) done_c = 1'b1;
      else if (state != IDLE)                         err_c  = 1'b1;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_n = CMD;
        CMD:     if (sclk_rise) state_n = ADDR;
        ADDR:    if (sclk_rise && cnt == ADDR_LAST) state_n = DATA;
        default: state_n = state;
      endcase
    end
  end

  // Falling edges are only acted on in the read data phase, which also makes
  // the leading falling edge of a CPOL=1 frame harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rw         <= 1'b0;
      words_done <= 1'b0;
      addr       <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      miso_q     <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      frame_done <= done_c;
      err_short  <= err_c;
      if (cs_rise) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              cnt        <= '0;
              words_done <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rw  <= mosi_s;
              cnt <= '0;
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr <= addr_nx;
              if (cnt == ADDR_LAST) begin
                cnt <= '0;
                if (!rw) tx_sh <= rd_word(addr_nx);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            if (sclk_rise) begin
              if (cnt == DATA_LAST) begin
                if (rw && addr_ok) mem[addr] <= rx_nx;
                addr       <= addr_inc;
                cnt        <= '0;
                words_done <= 1'b1;
                if (!rw) tx_sh <= rd_word(addr_inc);
              end else begin
                rx_sh <= rx_nx;
                cnt   <= cnt + CNT_W'(1);
              end
            end
            if (sclk_fall && !rw) begin
              miso_q <= tx_sh[DATA_W-1];
              tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
            end
          end
        endcase
      end
      if (state != DATA) miso_q <= 1'b0;
    end
  end

  assign miso_oe = (state == DATA) && !rw;
  assign miso    = miso_oe ? miso_q : 1'b0;

endmodule
